spi_shift_unit: RTL and testbench



---
 rtl/spi_shift_unit.sv | 176 +++++++++++++++++
 tb/tb_spi_shift_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_shift_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_shift_unit : serial-slave shift/rotate coprocessor    Rev 1.0    |
// +----------------------------------------------------------------------+
module spi_shift_unit #(
  parameter int WIDTH       = 16,
  parameter int OPCODE_BITS = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_nss,
  input  logic i_mosi,
  output logic o_miso,
  output logic o_busy
);

  localparam int IN_BITS  = OPCODE_BITS + 2 * WIDTH;
  localparam int OUT_BITS = WIDTH + 3;
  localparam int IN_CW    = $clog2(IN_BITS);
  localparam int OUT_CW   = $clog2(OUT_BITS);
  localparam int RW       = $clog2(WIDTH);

  localparam logic [IN_CW-1:0]       c_in_last  = IN_CW'(IN_BITS - 1);
  localparam logic [OUT_CW-1:0]      c_out_last = OUT_CW'(OUT_BITS - 1);
  localparam logic [WIDTH-1:0]       c_width_n  = WIDTH'(WIDTH);
  localparam logic [RW-1:0]          c_rot_max  = RW'(WIDTH - 1);
  localparam logic [OPCODE_BITS-1:0] c_op_rol   = OPCODE_BITS'(4);
  localparam logic [OPCODE_BITS-1:0] c_op_ror   = OPCODE_BITS'(5);
  localparam logic [OPCODE_BITS-1:0] c_op_sll   = OPCODE_BITS'(6);
  localparam logic [OPCODE_BITS-1:0] c_op_srl   = OPCODE_BITS'(7);
  localparam logic [OPCODE_BITS-1:0] c_op_sra   = OPCODE_BITS'(8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECEIVING,
    S_OPERATE,
    S_SEND_START,
    S_SENDING
  } state_t;

  state_t              r_state;
  logic [IN_BITS-1:0]  r_in_pkt;
  logic [OUT_BITS-1:0] r_out_pkt;
  logic [IN_CW-1:0]    r_in_cnt;
  logic [OUT_CW-1:0]   r_out_cnt;

  logic [OPCODE_BITS-1:0] w_op_code;
  logic [WIDTH-1:0]       w_op_1;
  logic [WIDTH-1:0]       w_op_2;
  logic [RW-1:0]          w_rot;
  logic [RW-1:0]          w_rinv;
  logic [RW-1:0]          w_samt;
  logic                   w_big;
  logic                   w_nz;
  logic [WIDTH-1:0]       w_rol;
  logic [WIDTH-1:0]       w_ror;
  logic [WIDTH:0]         w_sll_full;
  logic [WIDTH:0]         w_srx_full;
  logic signed [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0]       w_result;
  logic                   w_carry;
  logic                   w_err;
  logic                   w_zero;
  logic                   w_miso;

  assign w_op_code = r_in_pkt[OPCODE_BITS-1:0];
  assign w_op_1    = r_in_pkt[OPCODE_BITS+WIDTH-1:OPCODE_BITS];
  assign w_op_2    = r_in_pkt[IN_BITS-1:OPCODE_BITS+WIDTH];

  // Every shifter amount stays below WIDTH; rotate wrap-around uses an extra
  // single-bit pre-shift so r=0 never needs a WIDTH-position shift.
  always_comb begin
    w_rot      = RW'(w_op_2 % c_width_n);
    w_rinv     = c_rot_max - w_rot;
    w_big      = (w_op_2 >= c_width_n);
    w_nz       = (w_op_2 != '0);
    w_samt     = w_big ? '0 : RW'(w_op_2);
    w_rol      = (w_op_1 << w_rot) | ((w_op_1 >> 1) >> w_rinv);
    w_ror      = (w_op_1 >> w_rot) | ((w_op_1 << 1) << w_rinv);
    w_sll_full = {1'b0, w_op_1} << w_samt;
    w_srx_full = {w_op_1, 1'b0} >> w_samt;
    w_sra      = $signed(w_op_1) >>> w_samt;

    w_result = w_op_1;
    w_carry  = 1'b0;
    w_err    = 1'b0;
    case (w_op_code)
      c_op_rol: if (w_rot != '0) begin
        w_result = w_rol;
        w_carry  = w_rol[0];
      end
      c_op_ror: if (w_rot != '0) begin
        w_result = w_ror;
        w_carry  = w_ror[WIDTH-1];
      end
      c_op_sll: if (w_big) begin
        w_result = '0;
      end else if (w_nz) begin
        w_result = w_sll_full[WIDTH-1:0];
        w_carry  = w_sll_full[WIDTH];
      end
      c_op_srl: if (w_big) begin
        w_result = '0;
      end else if (w_nz) begin
        w_result = w_srx_full[WIDTH:1];
        w_carry  = w_srx_full[0];
      end
      c_op_sra: if (w_big) begin
        w_result = {WIDTH{w_op_1[WIDTH-1]}};
        w_carry  = w_op_1[WIDTH-1];
      end else if (w_nz) begin
        w_result = w_sra;
        w_carry  = w_srx_full[0];
      end
      default: w_err = 1'b1;
    endcase
    w_zero = (w_result == '0);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_in_pkt  <= '0;
      r_out_pkt <= '0;
    end else if (r_state != S_IDLE && i_nss) begin
      r_state   <= S_IDLE;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (!i_nss && i_mosi) r_state <= S_RECEIVING;
        S_RECEIVING: begin
          r_in_pkt[r_in_cnt] <= i_mosi;
          if (r_in_cnt == c_in_last) begin
            r_in_cnt <= '0;
            r_state  <= S_OPERATE;
          end else begin
            r_in_cnt <= r_in_cnt + IN_CW'(1);
          end
        end
        S_OPERATE: begin
          r_out_pkt <= {w_err, w_zero, w_carry, w_result};
          r_state   <= S_SEND_START;
        end
        S_SEND_START: if (!i_mosi) r_state <= S_SENDING;
        S_SENDING: begin
          if (r_out_cnt == c_out_last) begin
            r_out_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_out_cnt <= r_out_cnt + OUT_CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_miso = 1'b0;
    if (!i_nss) begin
      case (r_state)
        S_SEND_START: w_miso = 1'b1;
        S_SENDING:    w_miso = r_out_pkt[r_out_cnt];
        default:      w_miso = 1'b0;
      endcase
    end
  end

  assign o_miso = w_miso;
  assign o_busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_shift_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_shift_unit : vector table, corner sequences, random vs model  |
// +----------------------------------------------------------------------+
module tb_spi_shift_unit;

  localparam int W        = 16;
  localparam int IN_BITS  = 36;
  localparam int OUT_BITS = 19;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic nss     = 1'b1;
  logic mosi    = 1'b0;
  logic miso;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] n;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        e;
  } vec_t;

  vec_t vecs[15];

  spi_shift_unit #(.WIDTH(W), .OPCODE_BITS(4)) dut (
    .i_clock (clk),
    .i_reset (reset_n),
    .i_nss   (nss),
    .i_mosi  (mosi),
    .o_miso  (miso),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic chk_pkt(input string name, input logic [18:0] act, input logic [18:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (err,zero,carry,result)", name, act, exp);
    end
  endtask

  // Reference: shifts and rotates expressed as multiply/divide on integers.
  function automatic logic [18:0] model(input int op, input int a, input int n);
    int res, c, e, r, s, p, q;
    logic [18:0] ret;
    res = a; c = 0; e = 0;
    r = n % W;
    case (op)
      4: if (r != 0) begin
        res = (a * (1 << r)) % 65536 + a / (1 << (W - r));
        c   = res % 2;
      end
      5: if (r != 0) begin
        res = a / (1 << r) + (a * (1 << (W - r))) % 65536;
        c   = res / 32768;
      end
      6: if (n >= W) res = 0;
         else if (n >= 1) begin
           res = (a * (1 << n)) % 65536;
           c   = (a / (1 << (W - n))) % 2;
         end
      7: if (n >= W) res = 0;
         else if (n >= 1) begin
           res = a / (1 << n);
           c   = (a / (1 << (n - 1))) % 2;
         end
      8: begin
        s = (a >= 32768) ? a - 65536 : a;
        if (n >= W) begin
          res = (s < 0) ? 65535 : 0;
          c   = (s < 0) ? 1 : 0;
        end else if (n >= 1) begin
          p   = 1 << n;
          q   = (s >= 0) ? s / p : -((-s + p - 1) / p);
          res = (q < 0) ? q + 65536 : q;
          c   = (a / (1 << (n - 1))) % 2;
        end
      end
      default: e = 1;
    endcase
    ret = {e[0], (res == 0), c[0], res[15:0]};
    return ret;
  endfunction

  // Full transaction; rst_bit >= 0 asserts reset while that output bit is on the wire.
  task automatic run_txn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] n,
                         input int rst_bit, output logic [18:0] got);
    logic [35:0] pkt;
    pkt = {n, a, op};
    got = '0;
    @(negedge clk); nss = 1'b0; mosi = 1'b1;
    for (int i = 0; i < IN_BITS; i++) begin
      @(negedge clk); mosi = pkt[i];
    end
    @(negedge clk); mosi = 1'b1;
    chk_bit("operate_busy", busy, 1'b1);
    chk_bit("operate_miso", miso, 1'b0);
    @(negedge clk);
    chk_bit("start_miso", miso, 1'b1);
    @(negedge clk);
    chk_bit("start_hold_miso", miso, 1'b1);
    mosi = 1'b0;
    for (int b = 0; b < OUT_BITS; b++) begin
      @(negedge clk);
      got[b] = miso;
      if (b == rst_bit) begin
        chk_bit("rst_pre_busy", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk_bit("rst_async_miso", miso, 1'b0);
        chk_bit("rst_async_busy", busy, 1'b0);
        @(negedge clk); reset_n = 1'b1; nss = 1'b1;
        return;
      end
    end
    @(negedge clk);
    chk_bit("end_busy", busy, 1'b0);
    nss = 1'b1;
  endtask

  initial begin
    logic [18:0] got;
    logic [18:0] exp;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] n;

    vecs[0]  = '{4'h4, 16'h8001, 16'd1,     16'h0003, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{4'h5, 16'h0001, 16'd20,    16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'h5, 16'h0001, 16'd0,     16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'h8, 16'h8000, 16'd4,     16'hF800, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'h7, 16'h8000, 16'd4,     16'h0800, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'h6, 16'h00F0, 16'd16,    16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{4'hF, 16'h1234, 16'd3,     16'h1234, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{4'h6, 16'h8001, 16'd1,     16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'h8, 16'h8000, 16'd16,    16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{4'h8, 16'h4000, 16'hFFFF,  16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{4'h4, 16'h1234, 16'd16,    16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'h5, 16'h0001, 16'd1,     16'h8000, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{4'h7, 16'hC000, 16'd15,    16'h0001, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{4'h0, 16'h0000, 16'd5,     16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{4'h6, 16'h1234, 16'd0,     16'h1234, 1'b0, 1'b0, 1'b0};

    // Reset state, and IDLE ignoring a start bit while held in reset.
    #2 reset_n = 1'b0;
    #1;
    chk_bit("reset_busy", busy, 1'b0);
    chk_bit("reset_miso", miso, 1'b0);
    nss = 1'b0; mosi = 1'b1;
    repeat (2) @(negedge clk);
    chk_bit("reset_hold_busy", busy, 1'b0);
    nss = 1'b1; mosi = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk_bit("post_reset_busy", busy, 1'b0);

    for (int v = 0; v < 15; v++) begin
      run_txn(vecs[v].op, vecs[v].a, vecs[v].n, -1, got);
      exp = {vecs[v].e, vecs[v].z, vecs[v].c, vecs[v].res};
      chk_pkt($sformatf("vec%0d", v), got, exp);
    end

    // Abort after 10 received bits.
    @(negedge clk); nss = 1'b0; mosi = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); mosi = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    chk_bit("abort_pre_busy", busy, 1'b1);
    nss = 1'b1; mosi = 1'b0;
    #1;
    chk_bit("abort_miso", miso, 1'b0);
    @(negedge clk);
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_miso_idle", miso, 1'b0);
    run_txn(4'h4, 16'h8001, 16'd1, -1, got);
    chk_pkt("after_abort", got, {1'b0, 1'b0, 1'b1, 16'h0003});

    // Reset during output bit 5, then IDLE must ignore i_mosi=1 with i_nss=1.
    run_txn(4'h4, 16'h0020, 16'd0, 5, got);
    chk_bit("rst_bit5_seen", got[5], 1'b1);
    mosi = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_bit("post_rst_idle_busy", busy, 1'b0);
      chk_bit("post_rst_idle_miso", miso, 1'b0);
    end
    mosi = 1'b0;
    run_txn(4'h4, 16'h8001, 16'd1, -1, got);
    chk_pkt("after_reset", got, {1'b0, 1'b0, 1'b1, 16'h0003});

    // Randomized operations against the reference model.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(0, 15));
      else                           op = 4'($urandom_range(4, 8));
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       n = 16'($urandom_range(0, 17));
        1:       n = 16'($urandom);
        default: n = 16'($urandom_range(0, 15));
      endcase
      exp = model(int'(op), int'(a), int'(n));
      run_txn(op, a, n, -1, got);
      chk_pkt($sformatf("rnd%0d op=%h a=%h n=%h", k, op, a, n), got, exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
